// File: rtl/mem_stall_resp_pkg.sv
// rtl/mem_stall_resp_pkg.sv - shared state encoding, op codes and width default for mem_stall_resp
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int MEM_DW = 16;

endpackage

// File: rtl/mem_stall_resp_if.sv
// rtl/mem_stall_resp_if.sv - proc load/store port between the proc (master) and the stalling memory (slave)
interface mem_stall_resp_if
    import mem_pkg::*;
#(
    parameter int DW = MEM_DW
);
    logic          rd;
    logic          wr;
    logic [15:0]   addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          stall;
    logic          done;
    logic          busy;
    logic          err;

    modport master (
        output rd, wr, addr, data_in,
        input  data_out, stall, done, busy, err
    );

    modport slave (
        input  rd, wr, addr, data_in,
        output data_out, stall, done, busy, err
    );
endinterface

// File: rtl/mem_stall_resp_array.sv
// rtl/mem_stall_resp_array.sv - DEPTH x DW storage, synchronous write, combinational read, no reset
module mem_array
    import mem_pkg::*;
#(
    parameter int DW    = MEM_DW,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ridx,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/mem_stall_resp.sv
// rtl/mem_stall_resp.sv - fixed-latency stalling data memory; MEM_ALIGN_ERR_EN flags unaligned accesses
module mem_stall_resp
    import mem_pkg::*;
#(
    parameter int DW    = MEM_DW,
    parameter int DEPTH = 256,
    parameter int LAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_stall_resp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic          req_op;
    logic [AW-1:0] req_idx;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] data_out_q;
    logic          err_q;

    logic          req_valid, illegal, accept;
    logic [AW-1:0] live_idx;
    logic          live_op;
    logic          fire_now, fire_wait, fire;
    logic [AW-1:0] f_idx;
    logic          f_op;
    logic [DW-1:0] f_wdata;
    logic          drop;
    logic          arr_we;
    logic [DW-1:0] arr_rdata;

    assign req_valid = bus.rd ^ bus.wr;
    assign illegal   = bus.rd & bus.wr;
    assign accept    = (state == IDLE) && req_valid;
    // The shift drops the byte bit; the cast wraps addresses beyond DEPTH*2.
    assign live_idx  = AW'(bus.addr >> 1);
    assign live_op   = bus.wr ? OP_WR : OP_RD;

    // With LAT=1 the access happens on the accept edge using the live request.
    assign fire_now  = accept && (LAT == 1);
    assign fire_wait = (state == WAIT) && (cnt == 4'd1);
    assign fire      = fire_now || fire_wait;
    assign f_idx     = fire_now ? live_idx    : req_idx;
    assign f_op      = fire_now ? live_op     : req_op;
    assign f_wdata   = fire_now ? bus.data_in : req_wdata;

`ifdef MEM_ALIGN_ERR_EN
    logic req_unal;
    assign drop = fire_now ? bus.addr[0] : req_unal;
`else
    assign drop = 1'b0;
`endif

    assign arr_we = fire && (f_op == OP_WR) && !drop;

    mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .widx  (f_idx),
        .wdata (f_wdata),
        .ridx  (f_idx),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (LAT == 1) ? DONE : WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.stall = 1'b0;
        bus.done  = 1'b0;
        bus.busy  = 1'b0;
        if (!rst) begin
            bus.stall = accept || (state == WAIT);
            bus.done  = (state == DONE);
            bus.busy  = (state != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            req_op     <= OP_RD;
            req_idx    <= '0;
            req_wdata  <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
`ifdef MEM_ALIGN_ERR_EN
            req_unal   <= 1'b0;
`endif
        end else begin
            err_q <= ((state == IDLE) && illegal) || (fire && drop);
            if (accept) begin
                cnt       <= 4'(LAT - 1);
                req_op    <= live_op;
                req_idx   <= live_idx;
                req_wdata <= bus.data_in;
`ifdef MEM_ALIGN_ERR_EN
                req_unal  <= bus.addr[0];
`endif
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && ((f_op == OP_RD) || drop)) begin
                data_out_q <= drop ? '0 : arr_rdata;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_stall_resp.sv
// tb/tb_mem_stall_resp.sv - directed scoreboard bench for mem_stall_resp
module tb_mem_stall_resp;
    localparam int LAT = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [15:0] model [256];
    logic [15:0] exp_q [$];

    mem_stall_resp_if #(.DW(16)) bus ();

    mem_stall_resp #(
        .DW    (16),
        .DEPTH (256),
        .LAT   (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit is_wr, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] sh;
        logic [7:0]  idx;
        sh  = a >> 1;
        idx = sh[7:0];
        @(posedge clk);
        #1;
        bus.rd      = !is_wr;
        bus.wr      = is_wr;
        bus.addr    = a;
        bus.data_in = d;
`ifdef MEM_ALIGN_ERR_EN
        if (a[0]) begin
            if (!is_wr) exp_q.push_back(16'h0000);
        end else
`endif
        if (is_wr) model[idx] = d;
        else       exp_q.push_back(model[idx]);
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit is_rd, input bit exp_err, input int start);
        int          cyc;
        bit          got;
        logic [15:0] e;
        cyc = start;
        got = 1'b0;
        while (!got && cyc <= LAT + 4) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                check({tag, "_lat"}, cyc, LAT);
                check({tag, "_stall_in_done"}, bus.stall, 1'b0);
                check({tag, "_err"}, bus.err, exp_err);
                if (is_rd) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                    check({tag, "_data"}, bus.data_out, e);
                end
            end else begin
                check({tag, "_stall"}, bus.stall, 1'b1);
            end
            cyc++;
        end
        check({tag, "_done_seen"}, got, 1'b1);
    endtask

    initial begin
        int n_done;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.rd      = 1'b1;
        bus.wr      = 1'b0;
        bus.addr    = 16'h0000;
        bus.data_in = 16'h0000;

        // reset state, with a request showing while rst is held
        @(negedge clk);
        check("rst_stall", bus.stall, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.rd = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check("rst_data_out", bus.data_out, 16'h0000);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_stall_rel", bus.stall, 1'b0);
        check("rst_busy_rel", bus.busy, 1'b0);

        // write then read back
        issue(1'b1, 16'h0010, 16'hc010);
        wait_done("wr1", 1'b0, 1'b0, 0);
        drop_req();
        @(negedge clk);
        check("wr1_busy_after", bus.busy, 1'b0);
        check("wr1_done_after", bus.done, 1'b0);

        // read held through its own done: the next cycle is a fresh accept
        issue(1'b0, 16'h0010, 16'h0000);
        wait_done("rd1", 1'b1, 1'b0, 0);
        @(negedge clk);
        check("held_busy", bus.busy, 1'b0);
        check("held_done", bus.done, 1'b0);
        check("held_stall", bus.stall, 1'b1);
        exp_q.push_back(model[8]);
        wait_done("rd_held", 1'b1, 1'b0, 1);
        drop_req();
        @(negedge clk);
        check("held_done_after", bus.done, 1'b0);

        // illegal rd&wr
        @(posedge clk);
        #1;
        bus.rd      = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = 16'h0010;
        bus.data_in = 16'hffff;
        @(negedge clk);
        check("ill_stall", bus.stall, 1'b0);
        check("ill_err_c0", bus.err, 1'b0);
        drop_req();
        @(negedge clk);
        check("ill_err_c1", bus.err, 1'b1);
        check("ill_done_c1", bus.done, 1'b0);
        check("ill_busy_c1", bus.busy, 1'b0);
        @(negedge clk);
        check("ill_err_c2", bus.err, 1'b0);
        issue(1'b0, 16'h0010, 16'h0000);
        wait_done("ill_rd", 1'b1, 1'b0, 0);
        drop_req();

        // reset mid-write leaves the array untouched
        issue(1'b1, 16'h0020, 16'h0000);
        wait_done("wr20", 1'b0, 1'b0, 0);
        drop_req();
        issue(1'b1, 16'h0020, 16'h1234);
        model[16] = 16'h0000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_stall", bus.stall, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_data_out", bus.data_out, 16'h0000);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check("mid_rst_no_done", n_done, 0);
        issue(1'b0, 16'h0020, 16'h0000);
        wait_done("mid_rst_rd", 1'b1, 1'b0, 0);
        drop_req();

        // aliasing beyond DEPTH*2
        issue(1'b1, 16'h0200, 16'h00aa);
        wait_done("alias_wr", 1'b0, 1'b0, 0);
        drop_req();
        issue(1'b0, 16'h0000, 16'h0000);
        wait_done("alias_rd", 1'b1, 1'b0, 0);
        drop_req();

        // odd address: flagged when alignment checking is built in, else aligned word
`ifdef MEM_ALIGN_ERR_EN
        issue(1'b0, 16'h0011, 16'h0000);
        wait_done("unal_rd", 1'b1, 1'b1, 0);
`else
        issue(1'b0, 16'h0011, 16'h0000);
        wait_done("unal_rd", 1'b1, 1'b0, 0);
`endif
        drop_req();
        @(negedge clk);
        check("final_err", bus.err, 1'b0);
        check("final_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
